// File: rtl/gmii2fifo9_if.sv
// GMII receive inputs and 9-bit FIFO write port of gmii2fifo9.
interface gmii2fifo9_if;
   logic       gmii_rx_dv;
   logic       gmii_rx_er;
   logic [7:0] gmii_rxd;
   logic       full;
   logic [8:0] din;
   logic       wr_en;

   modport master (input gmii_rx_dv, gmii_rx_er, gmii_rxd, full, output din, wr_en);
   modport slave  (output gmii_rx_dv, gmii_rx_er, gmii_rxd, full, input din, wr_en);
endinterface

// File: rtl/gmii2fifo9.sv
// GMII receive front-end: strips preamble/SFD and writes {1,byte}/{0,status} words to a FIFO.
// Optional FCS stripping and checking is enabled by defining GMII2FIFO9_STRIP_FCS_EN.
module gmii2fifo9 #(
   parameter int unsigned PRE_MAX = 7,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             gmii_rx_clk,
   input  logic             sys_rst_n,
   gmii2fifo9_if.master     bus,
   output logic             wr_clk,
   output logic [CNT_W-1:0] rx_frames,
   output logic [CNT_W-1:0] rx_drops
);
   localparam int unsigned PC_W     = $clog2(PRE_MAX + 2);
   localparam logic [7:0]  PRE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE = 8'hD5;

   typedef enum logic [2:0] {IDLE, PRE, DATA, DROP, TERM} state_t;

   state_t           state, state_nxt;
   logic             dv_d;
   logic [PC_W-1:0]  pre_cnt, pre_cnt_nxt;
   logic             err, err_nxt;
   logic             fcs_bad, fcs_bad_nxt;
   logic             wrote, wrote_nxt;
   logic [8:0]       din_q, din_nxt;
   logic             wr_en_q, wr_en_nxt;
   logic [CNT_W-1:0] frames_nxt, drops_nxt;

   logic             dv, er, full, dv_rise;
   logic [7:0]       rxd;
   logic             pass_vld, short_frm, fcs_mis;
   logic [7:0]       pass_byte;

   assign wr_clk    = gmii_rx_clk;
   assign dv        = bus.gmii_rx_dv;
   assign er        = bus.gmii_rx_er;
   assign rxd       = bus.gmii_rxd;
   assign full      = bus.full;
   assign dv_rise   = dv & ~dv_d;
   assign bus.din   = din_q;
   assign bus.wr_en = wr_en_q;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Next state, write strobe and counter updates
   always_comb begin
      state_nxt   = state;
      pre_cnt_nxt = pre_cnt;
      err_nxt     = err;
      fcs_bad_nxt = fcs_bad;
      wrote_nxt   = wrote;
      din_nxt     = din_q;
      wr_en_nxt   = 1'b0;
      frames_nxt  = rx_frames;
      drops_nxt   = rx_drops;
      unique case (state)
         IDLE: begin
            if (dv_rise) begin
               err_nxt     = 1'b0;
               fcs_bad_nxt = 1'b0;
               wrote_nxt   = 1'b0;
               pre_cnt_nxt = '0;
               if (rxd == PRE_BYTE) begin
                  state_nxt   = PRE;
                  pre_cnt_nxt = PC_W'(1);
               end else if (rxd == SFD_BYTE) begin
                  state_nxt = DATA;
               end else begin
                  state_nxt = DROP;
                  drops_nxt = sat_inc(rx_drops);
               end
            end
         end
         PRE: begin
            if (!dv) begin
               state_nxt = IDLE;
            end else if (rxd == PRE_BYTE) begin
               if (pre_cnt >= PC_W'(PRE_MAX)) begin
                  state_nxt = DROP;
                  drops_nxt = sat_inc(rx_drops);
               end else begin
                  pre_cnt_nxt = pre_cnt + PC_W'(1);
               end
            end else if (rxd == SFD_BYTE) begin
               state_nxt = DATA;
            end else begin
               state_nxt = DROP;
               drops_nxt = sat_inc(rx_drops);
            end
         end
         DATA: begin
            if (!dv) begin
               state_nxt   = TERM;
               err_nxt     = err | short_frm;
               fcs_bad_nxt = fcs_mis;
            end else if (full) begin
               state_nxt = DROP;
               err_nxt   = 1'b1;
            end else begin
               if (er) err_nxt = 1'b1;
               if (pass_vld) begin
                  wr_en_nxt = 1'b1;
                  din_nxt   = {1'b1, pass_byte};
                  wrote_nxt = 1'b1;
               end
            end
         end
         DROP: begin
            if (!dv) state_nxt = wrote ? TERM : IDLE;
         end
         TERM: begin
            if (!full) begin
               wr_en_nxt = 1'b1;
               din_nxt   = {1'b0, 6'b0, fcs_bad, err};
               state_nxt = IDLE;
               if (err | fcs_bad) drops_nxt  = sat_inc(rx_drops);
               else               frames_nxt = sat_inc(rx_frames);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge gmii_rx_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= IDLE;
         dv_d      <= 1'b0;
         pre_cnt   <= '0;
         err       <= 1'b0;
         fcs_bad   <= 1'b0;
         wrote     <= 1'b0;
         din_q     <= '0;
         wr_en_q   <= 1'b0;
         rx_frames <= '0;
         rx_drops  <= '0;
      end else begin
         state     <= state_nxt;
         dv_d      <= dv;
         pre_cnt   <= pre_cnt_nxt;
         err       <= err_nxt;
         fcs_bad   <= fcs_bad_nxt;
         wrote     <= wrote_nxt;
         din_q     <= din_nxt;
         wr_en_q   <= wr_en_nxt;
         rx_frames <= frames_nxt;
         rx_drops  <= drops_nxt;
      end
   end

`ifdef GMII2FIFO9_STRIP_FCS_EN
   logic [3:0][7:0] pipe, pipe_nxt;
   logic [2:0]      fill, fill_nxt;
   logic [31:0]     crc, crc_nxt;
   logic            data_start, data_byte, term_entry;

   function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++)
         r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      return r;
   endfunction

   function automatic logic [31:0] bit_rev(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = v[31-i];
      return r;
   endfunction

   assign data_start = (state != DATA) && (state_nxt == DATA);
   assign data_byte  = (state == DATA) && dv && !full;
   assign term_entry = (state != TERM) && (state_nxt == TERM);

   // Four-byte hold-back pipe: the last four bytes of a frame (the FCS) never leave it
   always_comb begin
      pipe_nxt = pipe;
      fill_nxt = fill;
      crc_nxt  = crc;
      if (data_start) begin
         fill_nxt = '0;
         crc_nxt  = '1;
      end else if (data_byte) begin
         crc_nxt = crc_step(crc, rxd);
         if (fill == 3'd4) begin
            pipe_nxt = {rxd, pipe[3:1]};
         end else begin
            pipe_nxt[fill[1:0]] = rxd;
            fill_nxt            = fill + 3'd1;
         end
      end else if (term_entry) begin
         fill_nxt = '0;
      end
   end

   always_ff @(posedge gmii_rx_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         pipe <= '0;
         fill <= '0;
         crc  <= '1;
      end else begin
         pipe <= pipe_nxt;
         fill <= fill_nxt;
         crc  <= crc_nxt;
      end
   end

   assign pass_vld  = (fill == 3'd4);
   assign pass_byte = pipe[0];
   assign short_frm = (fill != 3'd4);
   // Register is LSB-first; the residue constant is in MSB-first form
   assign fcs_mis   = (bit_rev(crc) != 32'hC704_DD7B);
`else
   assign pass_vld  = 1'b1;
   assign pass_byte = rxd;
   assign short_frm = 1'b0;
   assign fcs_mis   = 1'b0;
`endif

endmodule

// File: tb/tb_gmii2fifo9.sv
// Directed scoreboard bench for gmii2fifo9; build with GMII2FIFO9_STRIP_FCS_EN to cover FCS stripping.
module tb_gmii2fifo9;
   localparam int unsigned PRE_MAX = 7;
   localparam int unsigned CNT_W   = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             wr_clk;
   logic [CNT_W-1:0] rx_frames, rx_drops;

   gmii2fifo9_if bus ();

   gmii2fifo9 #(.PRE_MAX(PRE_MAX), .CNT_W(CNT_W)) dut (
      .gmii_rx_clk (clk),
      .sys_rst_n   (rst_n),
      .bus         (bus),
      .wr_clk      (wr_clk),
      .rx_frames   (rx_frames),
      .rx_drops    (rx_drops)
   );

   always #5 clk = ~clk;

   int         total = 0;
   int         bad   = 0;
   int         data_seen = 0;
   int         exp_frames = 0;
   int         exp_drops  = 0;
   bit         chk_drops  = 1'b1;
   logic [8:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] crc32(input logic [7:0] b[$]);
      logic [31:0] c;
      c = '1;
      foreach (b[i]) begin
         c ^= {24'h0, b[i]};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      return c;
   endfunction

   // One GMII cycle; outputs sampled 1 time unit after the edge, full still as seen at the edge
   task automatic step(input logic dv, input logic er, input logic [7:0] d);
      logic [8:0] e;
      bus.gmii_rx_dv = dv;
      bus.gmii_rx_er = er;
      bus.gmii_rxd   = d;
      @(posedge clk);
      #1;
      check("wr_while_full", 32'(bus.wr_en & bus.full), 32'd0);
      if (bus.wr_en === 1'b1) begin
         check("write_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("din", 32'(bus.din), 32'(e));
         end
         if (bus.din[8]) data_seen++;
      end
   endtask

   task automatic send_frame(input int npre, input int nbytes, input int er_at,
                             input int full_at, input bit corrupt);
      logic [7:0]  fr[$];
      logic [31:0] c;
      logic [1:0]  st;
      int          pushed, d0;
      bit          dropped;
      dropped = (npre > int'(PRE_MAX));
      pushed  = 0;
      d0      = data_seen;
      for (int i = 0; i < nbytes; i++) fr.push_back(8'(i + 1));
`ifdef GMII2FIFO9_STRIP_FCS_EN
      c = ~crc32(fr);
      for (int k = 0; k < 4; k++) fr.push_back(c[8*k +: 8]);
      if (corrupt) fr[fr.size()-1] = fr[fr.size()-1] ^ 8'h01;
      st = {corrupt && (full_at == 0), (er_at != 0) || (full_at != 0)};
`else
      c  = 32'd0;
      st = {1'b0, (er_at != 0) || (full_at != 0)};
`endif
      for (int i = 0; i < npre; i++) step(1'b1, 1'b0, 8'h55);
      step(1'b1, 1'b0, 8'hD5);
      foreach (fr[i]) begin
         if (!dropped && i < nbytes && (full_at == 0 || pushed < full_at)) begin
            exp_q.push_back({1'b1, fr[i]});
            pushed++;
         end
         step(1'b1, 1'(i + 1 == er_at), fr[i]);
         if (full_at != 0 && data_seen - d0 >= full_at) bus.full = 1'b1;
      end
      if (!dropped) exp_q.push_back({1'b0, 6'b0, st});
      step(1'b0, 1'b0, 8'h00);
      bus.full = 1'b0;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);
      if (dropped || st != 2'b00) exp_drops++;
      else                        exp_frames++;
      check("frame_data_words", 32'(data_seen - d0), 32'(dropped ? 0 : pushed));
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      check("rx_frames", 32'(rx_frames), 32'(exp_frames));
      if (chk_drops) check("rx_drops", 32'(rx_drops), 32'(exp_drops));
   endtask

   initial begin
      int d0;
      rst_n          = 1'b0;
      bus.gmii_rx_dv = 1'b0;
      bus.gmii_rx_er = 1'b0;
      bus.gmii_rxd   = 8'h00;
      bus.full       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_wr_en", 32'(bus.wr_en), 32'd0);
      check("rst_din", 32'(bus.din), 32'd0);
      check("rst_frames", 32'(rx_frames), 32'd0);
      check("rst_drops", 32'(rx_drops), 32'd0);
      rst_n = 1'b1;
      step(1'b0, 1'b0, 8'h00);

      send_frame(7, 64, 0, 0, 1'b0);    // good 64-byte frame
      send_frame(7, 64, 10, 0, 1'b0);   // rx_er on byte 10
      send_frame(7, 64, 0, 20, 1'b0);   // FIFO full after 20 words
      send_frame(9, 8, 0, 0, 1'b0);     // preamble too long
      send_frame(7, 16, 0, 0, 1'b0);    // good frame after drop
      send_frame(7, 0, 0, 0, 1'b0);     // zero-length payload
      send_frame(0, 5, 0, 0, 1'b0);     // SFD with no preamble
      send_frame(7, 8, 0, 0, 1'b0);     // exactly PRE_MAX preamble bytes
`ifdef GMII2FIFO9_STRIP_FCS_EN
      send_frame(7, 64, 0, 0, 1'b1);    // corrupted FCS byte
`endif

      // Bad first byte and bad byte inside preamble: both dropped, nothing written
      d0 = data_seen;
      step(1'b1, 1'b0, 8'h12);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h20 + i));
      step(1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h55);
      step(1'b1, 1'b0, 8'hA7);
      step(1'b1, 1'b0, 8'hD5);
      step(1'b1, 1'b0, 8'h01);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);
      exp_drops += 2;
      check("bad_start_no_write", 32'(data_seen - d0), 32'd0);
      check("bad_start_queue", 32'(exp_q.size()), 32'd0);
      check("bad_start_drops", 32'(rx_drops), 32'(exp_drops));
      check("bad_start_frames", 32'(rx_frames), 32'(exp_frames));

      // Reset mid-frame, released while dv is still high
      d0 = data_seen;
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h55);
      rst_n = 1'b0;
      step(1'b1, 1'b0, 8'hD5);
      check("midrst_frames", 32'(rx_frames), 32'd0);
      check("midrst_wr_en", 32'(bus.wr_en), 32'd0);
      step(1'b1, 1'b0, 8'h37);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(8'h38 + i));
      for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 8'h00);
      check("midrst_no_write", 32'(data_seen - d0), 32'd0);
      exp_frames = 0;
      chk_drops  = 1'b0;
      send_frame(7, 12, 0, 0, 1'b0);    // first frame after reset

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
